// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner selection for a shared 4:1 data path.
// One owner at a time moves up to MAX_BURST words into a single registered
// output stage (valid/ready), then the grant rotates through one IDLE cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; scan req from ptr and latch the first one found
// XFER  | owner holds the mux; beats accepted while load_ok and cnt<MAX

module mux4_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    ptr;
    logic [1:0]    owner;
    logic [1:0]    pick;
    logic [CW-1:0] cnt;
    logic          req_own;
    logic          load_ok;
    logic          accept;
    logic          last_beat;
    logic [DW-1:0] in_sel;

    assign req_own   = req[owner];
    assign load_ok   = !out_valid || out_ready;
    assign accept    = (state == XFER) && req_own && load_ok && (cnt < CNT_MAX);
    assign last_beat = accept && (cnt == CNT_LAST);

    // Priority scan starting at ptr; walking offsets downward lets the
    // smallest offset (closest to ptr) win.
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
        end
    end

    // Data path mux steered by the current owner.
    always_comb begin
        case (owner)
            2'd0:    in_sel = in0;
            2'd1:    in_sel = in1;
            2'd2:    in_sel = in2;
            default: in_sel = in3;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: leave XFER on the final beat or when the owner lets go.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|req) state_nxt = XFER;
            XFER: if (!req_own || last_beat || (cnt >= CNT_MAX)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner, rotation pointer and burst counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= 2'd0;
            owner <= 2'd0;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                owner <= pick;
                cnt   <= '0;
            end
        end else begin
            if (accept) cnt <= cnt + CW'(1);
            if (state_nxt == IDLE) ptr <= owner + 2'd1;
        end
    end

    // Registered output stage; a simultaneous accept and drain keeps it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Outputs derived from state and the accept strobe.
    always_comb begin
        gnt        = 4'b0000;
        gnt[owner] = accept;
        sel        = owner;
        busy       = (state == XFER);
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter; inputs driven and outputs sampled on
// the falling clock edge.

module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    mux4_rr_arbiter #(.DW(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b1;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        req = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            $display("FAIL reset_pre: busy=%b out_valid=%b, want 1/1", busy, out_valid);
            n_err++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || out_data !== 8'h00) begin
            $display("FAIL reset_async: valid=%b gnt=%b sel=%0d busy=%b data=%h, want 0/0000/0/0/00",
                     out_valid, gnt, sel, busy, out_data);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            $display("FAIL reset_hold: gnt=%b busy=%b, want 0000/0", gnt, busy);
            n_err++;
        end
        rst_n = 1'b1;
        req = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        in0 = 8'hA5;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            $display("FAIL single_idle: busy=%b gnt=%b, want 0/0000", busy, gnt);
            n_err++;
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_cmp++;
            if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
                $display("FAIL single_gnt%0d: gnt=%b sel=%0d busy=%b, want 0001/0/1", j, gnt, sel, busy);
                n_err++;
            end
            if (j > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
                    $display("FAIL single_data%0d: valid=%b data=%h, want 1/a5", j, out_valid, out_data);
                    n_err++;
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
            $display("FAIL single_bubble: busy=%b gnt=%b valid=%b data=%h, want 0/0000/1/a5",
                     busy, gnt, out_valid, out_data);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || sel !== 2'd0 || gnt !== 4'b0001 || out_valid !== 1'b0) begin
            $display("FAIL single_regrant: busy=%b sel=%0d gnt=%b valid=%b, want 1/0/0001/0",
                     busy, sel, gnt, out_valid);
            n_err++;
        end
        req = 4'b0000;
    endtask

    task automatic test_contention();
        logic [7:0] vals [4];
        int k;
        int prev;
        vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30; vals[3] = 8'h40;
        do_reset();
        in0 = vals[0]; in1 = vals[1]; in2 = vals[2]; in3 = vals[3];
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            k = r % 4;
            prev = (r + 3) % 4;
            #1;
            n_cmp++;
            if (busy !== 1'b0 || gnt !== 4'b0000) begin
                $display("FAIL cont_bubble%0d: busy=%b gnt=%b, want 0/0000", r, busy, gnt);
                n_err++;
            end
            if (r > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== vals[prev]) begin
                    $display("FAIL cont_bubble_data%0d: valid=%b data=%h, want 1/%h", r, out_valid, out_data, vals[prev]);
                    n_err++;
                end
            end
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                n_cmp++;
                if (gnt !== (4'b0001 << k) || sel !== 2'(k) || busy !== 1'b1) begin
                    $display("FAIL cont_r%0d_b%0d: gnt=%b sel=%0d busy=%b, want %b/%0d/1",
                             r, j, gnt, sel, busy, 4'b0001 << k, k);
                    n_err++;
                end
                if (j > 0) begin
                    n_cmp++;
                    if (out_valid !== 1'b1 || out_data !== vals[k]) begin
                        $display("FAIL cont_data_r%0d_b%0d: valid=%b data=%h, want 1/%h", r, j, out_valid, out_data, vals[k]);
                        n_err++;
                    end
                end
            end
            @(negedge clk);
        end
        req = 4'b0000;
    endtask

    task automatic test_backpressure();
        int g;
        do_reset();
        req = 4'b0100;
        in2 = 8'h30;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            $display("FAIL bp_first: gnt=%b sel=%0d, want 0100/2", gnt, sel);
            n_err++;
        end
        @(negedge clk);
        in2 = 8'h31;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (gnt !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h30 || busy !== 1'b1) begin
                $display("FAIL bp_stall%0d: gnt=%b valid=%b data=%h busy=%b, want 0000/1/30/1",
                         s, gnt, out_valid, out_data, busy);
                n_err++;
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        g = 0;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            if (gnt === 4'b0100) g++;
            if (j == 1) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 8'h31) begin
                    $display("FAIL bp_resume_data: valid=%b data=%h, want 1/31", out_valid, out_data);
                    n_err++;
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (g !== 3) begin
            $display("FAIL bp_beats_after_stall: got %0d, want 3", g);
            n_err++;
        end
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            $display("FAIL bp_end: busy=%b gnt=%b, want 0/0000", busy, gnt);
            n_err++;
        end
        req = 4'b0000;
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0101;
        in0 = 8'h11;
        in2 = 8'h22;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_data !== 8'h11 || sel !== 2'd0 || gnt !== 4'b0001) begin
            $display("FAIL er_two_beats: data=%h sel=%0d gnt=%b, want 11/0/0001", out_data, sel, gnt);
            n_err++;
        end
        req = 4'b0100;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
            $display("FAIL er_drop: gnt=%b busy=%b, want 0000/1", gnt, busy);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            $display("FAIL er_idle: busy=%b gnt=%b, want 0/0000", busy, gnt);
            n_err++;
        end
        req = 4'b0101;
        @(negedge clk);
        n_cmp++;
        if (sel !== 2'd2 || gnt !== 4'b0100 || busy !== 1'b1) begin
            $display("FAIL er_next_owner: sel=%0d gnt=%b busy=%b, want 2/0100/1", sel, gnt, busy);
            n_err++;
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_burst();
        int g;
        do_reset();
        req = 4'b0010;
        in1 = 8'h55;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || sel !== 2'd1) begin
            $display("FAIL rmb_pre: valid=%b data=%h sel=%0d, want 1/55/1", out_valid, out_data, sel);
            n_err++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || gnt !== 4'b0000 || sel !== 2'd0) begin
            $display("FAIL rmb_clear: valid=%b data=%h busy=%b gnt=%b sel=%0d, want 0/00/0/0000/0",
                     out_valid, out_data, busy, gnt, sel);
            n_err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        g = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (gnt === 4'b0010 && sel === 2'd1) g++;
        end
        n_cmp++;
        if (g !== 4) begin
            $display("FAIL rmb_fresh_burst: got %0d beats, want 4", g);
            n_err++;
        end
        n_cmp++;
        if (busy !== 1'b0 || out_data !== 8'h55) begin
            $display("FAIL rmb_end: busy=%b data=%h, want 0/55", busy, out_data);
            n_err++;
        end
        req = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b1;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
